// File: rtl/icache_tag_array_if.sv
// Lookup, fill, invalidate and flush signals between the fetch pipeline and the icache tag array.
// The parity_error signal exists only when ICACHE_TAG_PARITY_EN is defined.
interface icache_tag_array_if #(
    parameter int unsigned WAYS = 2
);
    logic [31:0]     stage1_addr;
    logic            stage1_adv;
    logic [31:0]     stage2_addr;
    logic            ready;
    logic            tag_hit;
    logic [WAYS-1:0] tag_hit_way;
    logic            fill;
    logic [WAYS-1:0] fill_way;
    logic [WAYS-1:0] replacement_way;
    logic            inv_req;
    logic [31:0]     inv_addr;
    logic            flush_req;
    logic            flush_done;
`ifdef ICACHE_TAG_PARITY_EN
    logic            parity_error;
`endif

    modport master (
        output stage1_addr, stage1_adv, stage2_addr, fill, fill_way, inv_req, inv_addr, flush_req,
        input  ready, tag_hit, tag_hit_way, replacement_way, flush_done
`ifdef ICACHE_TAG_PARITY_EN
        , input parity_error
`endif
    );

    modport slave (
        input  stage1_addr, stage1_adv, stage2_addr, fill, fill_way, inv_req, inv_addr, flush_req,
        output ready, tag_hit, tag_hit_way, replacement_way, flush_done
`ifdef ICACHE_TAG_PARITY_EN
        , output parity_error
`endif
    );
endinterface

// File: rtl/icache_tag_array.sv
// N-way icache tag array: two-stage lookup, flush sweep FSM, line invalidation, round-robin victim.
// Define ICACHE_TAG_PARITY_EN to store an even-parity bit per entry and report parity_error.
module icache_tag_array #(
    parameter int unsigned WAYS            = 2,
    parameter int unsigned LINES           = 512,
    parameter int unsigned TAG_W           = 20,
    parameter int unsigned SUB_LINE_ADDR_W = 2,
    parameter int unsigned LINE_ADDR_W     = $clog2(LINES)
) (
    input logic               clk,
    input logic               rst,
    icache_tag_array_if.slave bus
);
    localparam int unsigned IDX_LSB = 2 + SUB_LINE_ADDR_W;
    localparam int unsigned TAG_LSB = IDX_LSB + LINE_ADDR_W;

    typedef struct packed {
`ifdef ICACHE_TAG_PARITY_EN
        logic             par;
`endif
        logic             valid;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic {FLUSH, IDLE} state_t;

    state_t                 state_q, state_d;
    logic [LINE_ADDR_W-1:0] cnt_q, cnt_d;
    logic                   flush_done_q, flush_done_d;
    logic [WAYS-1:0]        repl_q, repl_d;
    logic                   hit_allowed_q, collide_q;

    logic [WAYS-1:0]        we_c;
    logic [LINE_ADDR_W-1:0] waddr_c;
    entry_t                 wdata_c;
    logic                   fill_written_c;

    entry_t mem_q [WAYS][LINES];
    entry_t rd_q  [WAYS];

    logic [LINE_ADDR_W-1:0] rd_idx_c, inv_idx_c, fill_idx_c;
    logic [TAG_W-1:0]       cmp_tag_c;
    logic                   ready_c;
    logic [WAYS-1:0]        hit_way_c;
    logic [WAYS-1:0]        par_bad_c;

    assign rd_idx_c   = bus.stage1_addr[IDX_LSB +: LINE_ADDR_W];
    assign inv_idx_c  = bus.inv_addr[IDX_LSB +: LINE_ADDR_W];
    assign fill_idx_c = bus.stage2_addr[IDX_LSB +: LINE_ADDR_W];
    assign cmp_tag_c  = bus.stage2_addr[TAG_LSB +: TAG_W];
    assign ready_c    = (state_q == IDLE);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.stage1_addr, bus.stage2_addr, bus.inv_addr};

    // Sweep FSM and port-B arbiter: sweep > inv_req > fill; losers are dropped.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        flush_done_d   = 1'b0;
        repl_d         = repl_q;
        we_c           = '0;
        waddr_c        = '0;
        wdata_c        = '0;
        fill_written_c = 1'b0;
        case (state_q)
            FLUSH: begin
                we_c    = '1;
                waddr_c = cnt_q;
                if (bus.flush_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LINE_ADDR_W'(LINES - 1)) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    flush_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + LINE_ADDR_W'(1);
                end
            end
            default: begin
                if (bus.inv_req) begin
                    we_c    = '1;
                    waddr_c = inv_idx_c;
                end else if (bus.fill && (bus.fill_way != '0)) begin
                    we_c           = bus.fill_way;
                    waddr_c        = fill_idx_c;
                    wdata_c.valid  = 1'b1;
                    wdata_c.tag    = cmp_tag_c;
                    fill_written_c = 1'b1;
                end
                if (bus.flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
        endcase
`ifdef ICACHE_TAG_PARITY_EN
        wdata_c.par = ^{wdata_c.valid, wdata_c.tag};
`endif
        if (fill_written_c) begin
            repl_d = (repl_q << 1) | (repl_q >> (WAYS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FLUSH;
            cnt_q         <= '0;
            flush_done_q  <= 1'b0;
            repl_q        <= WAYS'(1);
            hit_allowed_q <= 1'b0;
            collide_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            flush_done_q  <= flush_done_d;
            repl_q        <= repl_d;
            hit_allowed_q <= bus.stage1_adv;
            collide_q     <= (we_c != '0) && (waddr_c == rd_idx_c);
        end
    end

    // Read-first dual-port tag RAMs; contents are never reset, the sweep clears them.
    always_ff @(posedge clk) begin
        for (int w = 0; w < int'(WAYS); w++) begin
            if (we_c[w]) mem_q[w][waddr_c] <= wdata_c;
            if (bus.stage1_adv) rd_q[w] <= mem_q[w][rd_idx_c];
        end
    end

    always_comb begin
        hit_way_c = '0;
        par_bad_c = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
`ifdef ICACHE_TAG_PARITY_EN
            par_bad_c[w] = ^{rd_q[w].par, rd_q[w].valid, rd_q[w].tag};
`endif
            hit_way_c[w] = hit_allowed_q & ready_c & ~collide_q & rd_q[w].valid
                         & (rd_q[w].tag == cmp_tag_c) & ~par_bad_c[w];
        end
    end

`ifdef ICACHE_TAG_PARITY_EN
    logic parity_error_q;
    always_ff @(posedge clk) begin
        if (rst) parity_error_q <= 1'b0;
        else     parity_error_q <= hit_allowed_q & ready_c & ~collide_q & (par_bad_c != '0);
    end
    assign bus.parity_error = parity_error_q;
`else
    logic unused_par;
    assign unused_par = ^par_bad_c;
`endif

    assign bus.ready           = ready_c;
    assign bus.tag_hit_way     = hit_way_c;
    assign bus.tag_hit         = (hit_way_c != '0);
    assign bus.replacement_way = repl_q;
    assign bus.flush_done      = flush_done_q;
endmodule

// File: tb/tb_icache_tag_array.sv
// Directed bench for icache_tag_array with WAYS=2, LINES=8: reset sweep, fill/lookup,
// invalidation, collision masking, replacement rotation and flush restart.
module tb_icache_tag_array;
    localparam int unsigned WAYS  = 2;
    localparam int unsigned LINES = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    icache_tag_array_if #(.WAYS(WAYS)) bus ();

    icache_tag_array #(
        .WAYS(WAYS), .LINES(LINES), .TAG_W(20), .SUB_LINE_ADDR_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] addr, input logic [1:0] exp_way);
        bus.stage1_addr = addr;
        bus.stage1_adv  = 1'b1;
        tick();
        bus.stage1_adv  = 1'b0;
        bus.stage2_addr = addr;
        #1;
        chk({tag, "_way"}, 32'(bus.tag_hit_way), 32'(exp_way));
        chk({tag, "_hit"}, 32'(bus.tag_hit), 32'(exp_way != 2'b00));
    endtask

    task automatic do_fill(input logic [31:0] addr, input logic [1:0] way);
        bus.stage2_addr = addr;
        bus.fill        = 1'b1;
        bus.fill_way    = way;
        tick();
        bus.fill        = 1'b0;
        bus.fill_way    = 2'b00;
    endtask

    // Expects LINES cycles of ready=0 starting now, then ready and flush_done together.
    task automatic expect_sweep(input string tag);
        for (int i = 0; i < int'(LINES); i++) begin
            chk({tag, "_busy"}, 32'(bus.ready), 32'd0);
            chk({tag, "_nodone"}, 32'(bus.flush_done), 32'd0);
            tick();
        end
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_done"}, 32'(bus.flush_done), 32'd1);
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.flush_done), 32'd0);
    endtask

    initial begin
        bus.stage1_addr = '0;
        bus.stage1_adv  = 1'b0;
        bus.stage2_addr = '0;
        bus.fill        = 1'b0;
        bus.fill_way    = '0;
        bus.inv_req     = 1'b0;
        bus.inv_addr    = '0;
        bus.flush_req   = 1'b0;

        tick();
        tick();
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_hit", 32'(bus.tag_hit), 32'd0);
        chk("rst_hit_way", 32'(bus.tag_hit_way), 32'd0);
        chk("rst_done", 32'(bus.flush_done), 32'd0);
        chk("rst_repl", 32'(bus.replacement_way), 32'd1);
`ifdef ICACHE_TAG_PARITY_EN
        chk("rst_parity", 32'(bus.parity_error), 32'd0);
`endif
        rst = 1'b0;
        expect_sweep("reset_sweep");
        lookup("post_reset", 32'h0000_1000, 2'b00);

        // Set 0: tag 0x20 into way 0, then a different tag in the same set.
        do_fill(32'h0000_1000, 2'b01);
        chk("repl_after_fill1", 32'(bus.replacement_way), 32'd2);
        lookup("hit_1000", 32'h0000_1000, 2'b01);
        lookup("miss_2000", 32'h0000_2000, 2'b00);

        // Sets 3 and 4, then invalidate set 3.
        do_fill(32'h0000_1030, 2'b01);
        do_fill(32'h0000_2030, 2'b10);
        do_fill(32'h0000_1040, 2'b01);
        chk("repl_after_fill4", 32'(bus.replacement_way), 32'd1);
        lookup("hit_1030", 32'h0000_1030, 2'b01);
        lookup("hit_2030", 32'h0000_2030, 2'b10);
        bus.inv_req  = 1'b1;
        bus.inv_addr = 32'h0000_0038;
        tick();
        bus.inv_req  = 1'b0;
        lookup("inv_1030", 32'h0000_1030, 2'b00);
        lookup("inv_2030", 32'h0000_2030, 2'b00);
        lookup("keep_1040", 32'h0000_1040, 2'b01);

        // inv + fill + lookup on set 4 in one cycle: fill dropped, lookup masked.
        bus.inv_req     = 1'b1;
        bus.inv_addr    = 32'h0000_0040;
        bus.fill        = 1'b1;
        bus.fill_way    = 2'b10;
        bus.stage2_addr = 32'h0000_2040;
        bus.stage1_addr = 32'h0000_1040;
        bus.stage1_adv  = 1'b1;
        tick();
        bus.inv_req     = 1'b0;
        bus.fill        = 1'b0;
        bus.fill_way    = 2'b00;
        bus.stage1_adv  = 1'b0;
        bus.stage2_addr = 32'h0000_1040;
        #1;
        chk("collide_hit", 32'(bus.tag_hit), 32'd0);
        chk("dropped_fill_repl", 32'(bus.replacement_way), 32'd1);
        lookup("inv_1040", 32'h0000_1040, 2'b00);
        lookup("dropped_2040", 32'h0000_2040, 2'b00);

        // Zero fill_way writes nothing and does not rotate.
        do_fill(32'h0000_1070, 2'b00);
        chk("zero_way_repl", 32'(bus.replacement_way), 32'd1);
        lookup("zero_way_1070", 32'h0000_1070, 2'b00);

        // Three fills following the suggested victim: 01, 10, 01.
        chk("rr_seq0", 32'(bus.replacement_way), 32'd1);
        do_fill(32'h0000_1050, bus.replacement_way);
        chk("rr_seq1", 32'(bus.replacement_way), 32'd2);
        do_fill(32'h0000_2050, bus.replacement_way);
        chk("rr_seq2", 32'(bus.replacement_way), 32'd1);
        do_fill(32'h0000_1060, bus.replacement_way);
        chk("rr_seq3", 32'(bus.replacement_way), 32'd2);
        lookup("hit_1050", 32'h0000_1050, 2'b01);
        lookup("hit_2050", 32'h0000_2050, 2'b10);
        lookup("hit_1060", 32'h0000_1060, 2'b01);

        // fence.i flush, restarted after three sweep cycles.
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        chk("flush_busy0", 32'(bus.ready), 32'd0);
        tick();
        chk("flush_busy1", 32'(bus.ready), 32'd0);
        tick();
        chk("flush_busy2", 32'(bus.ready), 32'd0);
        bus.flush_req = 1'b1;
        tick();
        bus.flush_req = 1'b0;
        expect_sweep("restart_sweep");
        lookup("flushed_1050", 32'h0000_1050, 2'b00);
        lookup("flushed_2050", 32'h0000_2050, 2'b00);
        lookup("flushed_1060", 32'h0000_1060, 2'b00);
        lookup("flushed_1000", 32'h0000_1000, 2'b00);
`ifdef ICACHE_TAG_PARITY_EN
        tick();
        chk("no_parity_error", 32'(bus.parity_error), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
